// File: rtl/icache_refill_ctlr_pkg.sv
// Shared icache refill definitions: FSM state encoding and block-offset sizing.
package icache_refill_ctlr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } refill_state_t;

    // Byte offset of a word within a block; words are 4 bytes wide.
    localparam int unsigned WORD_OFF_W = 32'd2;

    function automatic int unsigned blk_off_w(input int unsigned words);
        return $clog2(words) + WORD_OFF_W;
    endfunction

    localparam int unsigned BLK_OFF_W = blk_off_w(32'd4);

endpackage

// File: rtl/icache_refill_ctlr_beat_ctr.sv
// Refill beat counter: cleared when a burst is accepted, counts returned beats,
// and flags the final beat of the block.
module refill_beat_ctr #(
    parameter int unsigned B  = 4,
    parameter int unsigned CW = $clog2(B)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (inc_i) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == CW'(B - 1));

endmodule

// File: rtl/icache_refill_ctlr.sv
// Instruction-cache line refill controller: issues a block read burst on a miss
// and streams returned beats into the replacement line.
module icache_refill_ctlr
    import icache_refill_ctlr_pkg::*;
#(
    parameter int unsigned B  = 4,
    parameter int unsigned AW = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 instr_miss_f_i,
    input  logic                 instr_cache_rep_active_i,
    input  logic [AW-1:0]        pc_f_i,
    input  logic                 flush_i,
    output logic                 mem_req_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic                 mem_ack_i,
    input  logic                 mem_rvalid_i,
    input  logic [AW-1:0]        mem_rdata_i,
    output logic                 rep_we_o,
    output logic [$clog2(B)-1:0] rep_word_o,
    output logic [AW-1:0]        rep_data_o,
    output logic [AW-1:0]        rep_addr_o,
    output logic                 rep_done_o,
    output logic                 refill_busy_o
);

    localparam int unsigned CW   = $clog2(B);
    localparam int unsigned OFFW = blk_off_w(B);
    localparam logic [AW-1:0] BLK_MASK = {AW{1'b1}} << OFFW;

    refill_state_t state_q;
    refill_state_t state_d;
    logic [AW-1:0] base_q;
    logic [AW-1:0] base_d;
    logic          start_s;
    logic          ctr_clr_s;
    logic          ctr_inc_s;
    logic [CW-1:0] cnt_s;
    logic          last_s;

    assign start_s   = instr_miss_f_i & instr_cache_rep_active_i & ~flush_i;
    // The counter restarts whenever the burst is accepted, whether it will be kept or drained.
    assign ctr_clr_s = (state_q == ST_REQ) & mem_ack_i;
    assign ctr_inc_s = ((state_q == ST_FILL) | (state_q == ST_DRAIN)) & mem_rvalid_i;

    refill_beat_ctr #(
        .B  (B),
        .CW (CW)
    ) u_beat_ctr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (ctr_clr_s),
        .inc_i   (ctr_inc_s),
        .cnt_o   (cnt_s),
        .last_o  (last_s)
    );

    // State and latched block base.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            base_q  <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // Next-state and base-capture logic.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_REQ;
                    base_d  = pc_f_i & BLK_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack_i) begin
                    state_d = flush_i ? ST_DRAIN : ST_FILL;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_FILL: begin
                // A flush on the final beat has nothing left to drain.
                if (mem_rvalid_i && last_s) begin
                    state_d = flush_i ? ST_IDLE : ST_DONE;
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid_i && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; line writes pass the beat through with zero latency.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = {AW{1'b0}};
        rep_we_o      = 1'b0;
        rep_word_o    = {CW{1'b0}};
        rep_data_o    = {AW{1'b0}};
        rep_done_o    = 1'b0;
        refill_busy_o = 1'b1;
        case (state_q)
            ST_IDLE: begin
                refill_busy_o = 1'b0;
            end
            ST_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = base_q;
            end
            ST_FILL: begin
                if (mem_rvalid_i && !flush_i) begin
                    rep_we_o   = 1'b1;
                    rep_word_o = cnt_s;
                    rep_data_o = mem_rdata_i;
                end else begin
                    rep_we_o   = 1'b0;
                end
            end
            ST_DRAIN: begin
                rep_we_o = 1'b0;
            end
            ST_DONE: begin
                rep_done_o = 1'b1;
            end
            default: begin
                refill_busy_o = 1'b0;
            end
        endcase
    end

    assign rep_addr_o = base_q;

endmodule

// File: tb/tb_icache_refill_ctlr.sv
// Directed, table-driven bench for icache_refill_ctlr (B=4, AW=32).
module tb_icache_refill_ctlr;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        instr_miss_f_i;
    logic        instr_cache_rep_active_i;
    logic [31:0] pc_f_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rep_we_o;
    logic [1:0]  rep_word_o;
    logic [31:0] rep_data_o;
    logic [31:0] rep_addr_o;
    logic        rep_done_o;
    logic        refill_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    icache_refill_ctlr #(.B(4), .AW(32)) dut (
        .clk_i                    (clk_i),
        .reset_i                  (reset_i),
        .instr_miss_f_i           (instr_miss_f_i),
        .instr_cache_rep_active_i (instr_cache_rep_active_i),
        .pc_f_i                   (pc_f_i),
        .flush_i                  (flush_i),
        .mem_req_o                (mem_req_o),
        .mem_addr_o               (mem_addr_o),
        .mem_ack_i                (mem_ack_i),
        .mem_rvalid_i             (mem_rvalid_i),
        .mem_rdata_i              (mem_rdata_i),
        .rep_we_o                 (rep_we_o),
        .rep_word_o               (rep_word_o),
        .rep_data_o               (rep_data_o),
        .rep_addr_o               (rep_addr_o),
        .rep_done_o               (rep_done_o),
        .refill_busy_o            (refill_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        req;
        logic [31:0] maddr;
        logic        we;
        logic [1:0]  word;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic        done;
        logic        busy;
    } out_t;

    typedef struct packed {
        logic        miss;
        logic        act;
        logic [31:0] pc;
        logic        flush;
        logic        ack;
        logic        rv;
        logic [31:0] rdata;
        out_t        exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic miss, input logic act, input logic [31:0] pc,
                                input logic flush, input logic ack, input logic rv,
                                input logic [31:0] rdata, input logic req, input logic [31:0] maddr,
                                input logic we, input logic [1:0] word, input logic [31:0] wdata,
                                input logic [31:0] raddr, input logic done, input logic busy);
        vec_t v;
        v.miss = miss; v.act = act; v.pc = pc; v.flush = flush; v.ack = ack; v.rv = rv;
        v.rdata = rdata;
        v.exp.req = req; v.exp.maddr = maddr; v.exp.we = we; v.exp.word = word;
        v.exp.wdata = wdata; v.exp.raddr = raddr; v.exp.done = done; v.exp.busy = busy;
        return v;
    endfunction

    task automatic drive(input logic miss, input logic act, input logic [31:0] pc,
                         input logic flush, input logic ack, input logic rv,
                         input logic [31:0] rdata);
        instr_miss_f_i = miss; instr_cache_rep_active_i = act; pc_f_i = pc;
        flush_i = flush; mem_ack_i = ack; mem_rvalid_i = rv; mem_rdata_i = rdata;
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act.req = mem_req_o; act.maddr = mem_addr_o; act.we = rep_we_o; act.word = rep_word_o;
        act.wdata = rep_data_o; act.raddr = rep_addr_o; act.done = rep_done_o;
        act.busy = refill_busy_o;
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got req=%b maddr=%h we=%b word=%0d data=%h raddr=%h done=%b busy=%b; expected req=%b maddr=%h we=%b word=%0d data=%h raddr=%h done=%b busy=%b",
                     name, act.req, act.maddr, act.we, act.word, act.wdata, act.raddr, act.done, act.busy,
                     exp.req, exp.maddr, exp.we, exp.word, exp.wdata, exp.raddr, exp.done, exp.busy);
        end
        n_checks++;
        if ((int'(mem_req_o) + int'(rep_we_o) + int'(rep_done_o)) > 1) begin
            n_errors++;
            $display("FAIL %s_exclusive: got req=%b we=%b done=%b, expected at most one high",
                     name, mem_req_o, rep_we_o, rep_done_o);
        end
    endtask

    function automatic out_t idle_out(input logic [31:0] raddr);
        out_t o;
        o = '0;
        o.raddr = raddr;
        return o;
    endfunction

    function automatic out_t req_out(input logic [31:0] base);
        out_t o;
        o = '0;
        o.req = 1'b1; o.maddr = base; o.raddr = base; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t wr_out(input logic [31:0] base, input logic [1:0] word,
                                    input logic [31:0] data);
        out_t o;
        o = '0;
        o.we = 1'b1; o.word = word; o.wdata = data; o.raddr = base; o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t busy_out(input logic [31:0] base, input logic done);
        out_t o;
        o = '0;
        o.raddr = base; o.busy = 1'b1; o.done = done;
        return o;
    endfunction

    function automatic vec_t mv(input logic miss, input logic act, input logic [31:0] pc,
                                input logic flush, input logic ack, input logic rv,
                                input logic [31:0] rdata, input out_t e);
        return mk(miss, act, pc, flush, ack, rv, rdata, e.req, e.maddr, e.we, e.word, e.wdata,
                  e.raddr, e.done, e.busy);
    endfunction

    initial begin
        // Basic refill: miss at 0x1234, ack next cycle, four back-to-back beats.
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0)));
        tbl.push_back(mv(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, req_out(32'h0000_1230)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA0A0_0000, wr_out(32'h0000_1230, 2'd0, 32'hA0A0_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA1A1_0001, wr_out(32'h0000_1230, 2'd1, 32'hA1A1_0001)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA2A2_0002, wr_out(32'h0000_1230, 2'd2, 32'hA2A2_0002)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA3A3_0003, wr_out(32'h0000_1230, 2'd3, 32'hA3A3_0003)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, busy_out(32'h0000_1230, 1'b1)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hEEEE_EEEE, idle_out(32'h0000_1230)));
        // Miss without replacement permission, and miss coincident with flush: stay idle.
        tbl.push_back(mv(1'b1, 1'b0, 32'h0000_9990, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_1230)));
        tbl.push_back(mv(1'b1, 1'b1, 32'h0000_8880, 1'b1, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_1230)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_1230)));
        // Ack delayed five cycles, stray beat in REQ, gapped beats.
        tbl.push_back(mv(1'b1, 1'b1, 32'h0000_ABCC, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_1230)));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0, 32'hFFFF_FFFF, req_out(32'h0000_ABC0)));
        end
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, req_out(32'h0000_ABC0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, busy_out(32'h0000_ABC0, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB000_0000, wr_out(32'h0000_ABC0, 2'd0, 32'hB000_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, busy_out(32'h0000_ABC0, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB111_1111, wr_out(32'h0000_ABC0, 2'd1, 32'hB111_1111)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB222_2222, wr_out(32'h0000_ABC0, 2'd2, 32'hB222_2222)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, busy_out(32'h0000_ABC0, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hB333_3333, wr_out(32'h0000_ABC0, 2'd3, 32'hB333_3333)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, busy_out(32'h0000_ABC0, 1'b1)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_ABC0)));
        // Flush in REQ before ack withdraws the request.
        tbl.push_back(mv(1'b1, 1'b1, 32'h2000_0008, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_ABC0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, req_out(32'h2000_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, idle_out(32'h2000_0000)));
        // Flush on beat 1: beat suppressed, beats 2-3 drained, flush in DRAIN ignored.
        tbl.push_back(mv(1'b1, 1'b1, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h2000_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, req_out(32'h0000_4440)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC000_0000, wr_out(32'h0000_4440, 2'd0, 32'hC000_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC111_1111, busy_out(32'h0000_4440, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hC222_2222, busy_out(32'h0000_4440, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC333_3333, busy_out(32'h0000_4440, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_4440)));
        // New miss accepted; flush on the final beat returns straight to IDLE.
        tbl.push_back(mv(1'b1, 1'b1, 32'h0000_5550, 1'b0, 1'b0, 1'b0, 32'h0, idle_out(32'h0000_4440)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, req_out(32'h0000_5550)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hD000_0000, wr_out(32'h0000_5550, 2'd0, 32'hD000_0000)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hD111_1111, wr_out(32'h0000_5550, 2'd1, 32'hD111_1111)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hD222_2222, wr_out(32'h0000_5550, 2'd2, 32'hD222_2222)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hD333_3333, busy_out(32'h0000_5550, 1'b0)));
        tbl.push_back(mv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hD444_4444, idle_out(32'h0000_5550)));

        reset_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        check_out("reset_state", idle_out(32'h0));
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            drive(tbl[i].miss, tbl[i].act, tbl[i].pc, tbl[i].flush, tbl[i].ack, tbl[i].rv, tbl[i].rdata);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset asserted in the middle of beat 2.
        @(negedge clk_i);
        drive(1'b1, 1'b1, 32'h0000_7778, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 check_out("rst_req", req_out(32'h0000_7770));
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE000_0000);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE111_1111);
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE222_2222);
        #1 check_out("rst_beat2", wr_out(32'h0000_7770, 2'd2, 32'hE222_2222));
        #1 reset_i = 1'b0;
        #1 check_out("rst_async", idle_out(32'h0));
        @(negedge clk_i);
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hE333_3333);
        #1 check_out("rst_stray", idle_out(32'h0));
        @(negedge clk_i);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1 check_out("rst_after", idle_out(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
